// File: rtl/rsa_systolic_mm.sv
// rsa_systolic_mm: output-stationary systolic matrix multiplier, C = A x B.
// A (X x N) arrives row-major on Xin, B (N x Y) column-major on Yin. After a
// SA_start pulse the X x Y PE grid runs N skewed MACs per PE, then the X*Y
// results are shifted out row-major on out_data, one per cycle.
module rsa_systolic_mm #(
    parameter int X          = 3,
    parameter int N          = 4,
    parameter int Y          = 3,
    parameter int IN_LEN     = 4,
    parameter int OUT_LEN    = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              SA_start,
    input  logic              Xin_val,
    input  logic [IN_LEN:1]   Xin_data,
    input  logic              Yin_val,
    input  logic [IN_LEN:1]   Yin_data,
    output logic [OUT_LEN:1]  out_data
);

    localparam int ROW_W    = (X > 1) ? $clog2(X) : 1;
    localparam int COL_W    = (Y > 1) ? $clog2(Y) : 1;
    localparam int CYC_W    = $clog2(N + X + Y + 1) + 1;
    localparam int LAST_CYC = N + X + Y - 1;

    localparam logic [IN_LEN-1:0]     IN_ZERO   = {IN_LEN{1'b0}};
    localparam logic [OUT_LEN-1:0]    OUT_ZERO  = {OUT_LEN{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(N - 1);
    localparam logic [ROW_W-1:0]      ROW_ZERO  = {ROW_W{1'b0}};
    localparam logic [ROW_W-1:0]      ROW_ONE   = ROW_W'(1'b1);
    localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(X - 1);
    localparam logic [COL_W-1:0]      COL_ZERO  = {COL_W{1'b0}};
    localparam logic [COL_W-1:0]      COL_ONE   = COL_W'(1'b1);
    localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(Y - 1);
    localparam logic [CYC_W-1:0]      CYC_ZERO  = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0]      CYC_ONE   = CYC_W'(1'b1);
    localparam logic [CYC_W-1:0]      CYC_LAST  = CYC_W'(LAST_CYC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    // One MAC step: unsigned product, zero-extended, accumulated modulo 2^OUT_LEN.
    function automatic logic [OUT_LEN-1:0] mac_step(input logic [OUT_LEN-1:0] acc,
                                                    input logic [IN_LEN-1:0]  a,
                                                    input logic [IN_LEN-1:0]  b);
        logic [2*IN_LEN-1:0] prod;
        prod = a * b;
        return acc + OUT_LEN'(prod);
    endfunction

    state_t                  state_r, state_s;
    logic                    start_s, load_a_s, load_b_s;
    logic [ROW_W-1:0]        a_row_r;
    logic [ADDR_WIDTH-1:0]   a_addr_r;
    logic                    a_full_r;
    logic [COL_W-1:0]        b_col_r;
    logic [ADDR_WIDTH-1:0]   b_addr_r;
    logic                    b_full_r;
    logic [CYC_W-1:0]        cyc_r;
    logic [IN_LEN-1:0]       a_buf_r  [X][N];
    logic [IN_LEN-1:0]       b_buf_r  [Y][N];
    logic [IN_LEN-1:0]       a_feed_s [X];
    logic [IN_LEN-1:0]       b_feed_s [Y];
    logic [IN_LEN-1:0]       a_in_s   [X][Y];
    logic [IN_LEN-1:0]       b_in_s   [X][Y];
    logic [IN_LEN-1:0]       a_pipe_r [X][Y];
    logic [IN_LEN-1:0]       b_pipe_r [X][Y];
    logic [OUT_LEN-1:0]      acc_r    [X][Y];
    logic [ROW_W-1:0]        out_row_r;
    logic [COL_W-1:0]        out_col_r;
    logic                    out_done_r;
    logic [OUT_LEN-1:0]      out_data_r;

    // A start edge freezes the buffers, so loads are blocked on that edge.
    assign start_s  = (state_r == IDLE) && SA_start;
    assign load_a_s = (state_r == IDLE) && !SA_start && Xin_val && !a_full_r;
    assign load_b_s = (state_r == IDLE) && !SA_start && Yin_val && !b_full_r;
    assign out_data = out_data_r;

    // FSM state register.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_r <= IDLE;
        else            state_r <= state_s;
    end

    // FSM next state: IDLE -> COMPUTE -> OUTPUT -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (SA_start) state_s = COMPUTE;
                else          state_s = IDLE;
            end
            COMPUTE: begin
                if (cyc_r == CYC_LAST) state_s = OUTPUT;
                else                   state_s = COMPUTE;
            end
            OUTPUT: begin
                if (out_done_r) state_s = IDLE;
                else            state_s = OUTPUT;
            end
            default: state_s = IDLE;
        endcase
    end

    // A write pointer: row-major, saturating, rewound whenever Xin_val drops in IDLE.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_row_r  <= ROW_ZERO;
            a_addr_r <= ADDR_ZERO;
            a_full_r <= 1'b0;
        end else if (state_r == IDLE && !Xin_val) begin
            a_row_r  <= ROW_ZERO;
            a_addr_r <= ADDR_ZERO;
            a_full_r <= 1'b0;
        end else if (load_a_s) begin
            if (a_addr_r == ADDR_LAST) begin
                a_addr_r <= ADDR_ZERO;
                if (a_row_r == ROW_LAST) a_full_r <= 1'b1;
                else                     a_row_r  <= a_row_r + ROW_ONE;
            end else begin
                a_addr_r <= a_addr_r + ADDR_ONE;
            end
        end
    end

    // B write pointer: column-major, saturating, rewound whenever Yin_val drops in IDLE.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            b_col_r  <= COL_ZERO;
            b_addr_r <= ADDR_ZERO;
            b_full_r <= 1'b0;
        end else if (state_r == IDLE && !Yin_val) begin
            b_col_r  <= COL_ZERO;
            b_addr_r <= ADDR_ZERO;
            b_full_r <= 1'b0;
        end else if (load_b_s) begin
            if (b_addr_r == ADDR_LAST) begin
                b_addr_r <= ADDR_ZERO;
                if (b_col_r == COL_LAST) b_full_r <= 1'b1;
                else                     b_col_r  <= b_col_r + COL_ONE;
            end else begin
                b_addr_r <= b_addr_r + ADDR_ONE;
            end
        end
    end

    // Compute cycle counter; holds the index c of the upcoming edge during COMPUTE.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                cyc_r <= CYC_ZERO;
        else if (start_s)              cyc_r <= CYC_ONE;
        else if (state_r == COMPUTE)   cyc_r <= cyc_r + CYC_ONE;
        else                           cyc_r <= CYC_ZERO;
    end

    for (genvar gi = 0; gi < X; gi++) begin : g_a_row
        localparam logic [CYC_W-1:0] A_FIRST = CYC_W'(gi + 1);
        localparam logic [CYC_W-1:0] A_END   = CYC_W'(gi + 1 + N);

        for (genvar gk = 0; gk < N; gk++) begin : g_a_word
            // A buffer entry (row gi, address gk).
            always_ff @(posedge clk or negedge sys_rst_n) begin
                if (!sys_rst_n)
                    a_buf_r[gi][gk] <= IN_ZERO;
                else if (load_a_s && a_row_r == ROW_W'(gi) && a_addr_r == ADDR_WIDTH'(gk))
                    a_buf_r[gi][gk] <= Xin_data;
            end
        end

        // Left-edge feed for row gi, skewed gi cycles late; bubbles carry zero.
        always_comb begin
            a_feed_s[gi] = IN_ZERO;
            if (state_r == COMPUTE && cyc_r >= A_FIRST && cyc_r < A_END)
                a_feed_s[gi] = a_buf_r[gi][ADDR_WIDTH'(cyc_r - A_FIRST)];
            else
                a_feed_s[gi] = IN_ZERO;
        end
    end

    for (genvar gj = 0; gj < Y; gj++) begin : g_b_col
        localparam logic [CYC_W-1:0] B_FIRST = CYC_W'(gj + 1);
        localparam logic [CYC_W-1:0] B_END   = CYC_W'(gj + 1 + N);

        for (genvar gk = 0; gk < N; gk++) begin : g_b_word
            // B buffer entry (column gj, address gk).
            always_ff @(posedge clk or negedge sys_rst_n) begin
                if (!sys_rst_n)
                    b_buf_r[gj][gk] <= IN_ZERO;
                else if (load_b_s && b_col_r == COL_W'(gj) && b_addr_r == ADDR_WIDTH'(gk))
                    b_buf_r[gj][gk] <= Yin_data;
            end
        end

        // Top-edge feed for column gj, skewed gj cycles late; bubbles carry zero.
        always_comb begin
            b_feed_s[gj] = IN_ZERO;
            if (state_r == COMPUTE && cyc_r >= B_FIRST && cyc_r < B_END)
                b_feed_s[gj] = b_buf_r[gj][ADDR_WIDTH'(cyc_r - B_FIRST)];
            else
                b_feed_s[gj] = IN_ZERO;
        end
    end

    for (genvar gi = 0; gi < X; gi++) begin : g_pe_row
        for (genvar gj = 0; gj < Y; gj++) begin : g_pe_col
            if (gj == 0) begin : g_a_edge
                assign a_in_s[gi][gj] = a_feed_s[gi];
            end else begin : g_a_inner
                assign a_in_s[gi][gj] = a_pipe_r[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_in_s[gi][gj] = b_feed_s[gj];
            end else begin : g_b_inner
                assign b_in_s[gi][gj] = b_pipe_r[gi-1][gj];
            end

            // PE(gi,gj): pass A right and B down, accumulate their product in place.
            always_ff @(posedge clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    a_pipe_r[gi][gj] <= IN_ZERO;
                    b_pipe_r[gi][gj] <= IN_ZERO;
                    acc_r[gi][gj]    <= OUT_ZERO;
                end else if (start_s) begin
                    a_pipe_r[gi][gj] <= IN_ZERO;
                    b_pipe_r[gi][gj] <= IN_ZERO;
                    acc_r[gi][gj]    <= OUT_ZERO;
                end else if (state_r == COMPUTE) begin
                    a_pipe_r[gi][gj] <= a_in_s[gi][gj];
                    b_pipe_r[gi][gj] <= b_in_s[gi][gj];
                    acc_r[gi][gj]    <= mac_step(acc_r[gi][gj], a_in_s[gi][gj], b_in_s[gi][gj]);
                end
            end
        end
    end

    // Result serialiser: one accumulator per cycle in row-major order, then zero.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_data_r <= OUT_ZERO;
            out_row_r  <= ROW_ZERO;
            out_col_r  <= COL_ZERO;
            out_done_r <= 1'b0;
        end else begin
            case (state_r)
                OUTPUT: begin
                    if (out_done_r) begin
                        out_data_r <= OUT_ZERO;
                        out_done_r <= 1'b0;
                    end else begin
                        out_data_r <= acc_r[out_row_r][out_col_r];
                        if (out_col_r == COL_LAST) begin
                            out_col_r <= COL_ZERO;
                            if (out_row_r == ROW_LAST) out_done_r <= 1'b1;
                            else                       out_row_r  <= out_row_r + ROW_ONE;
                        end else begin
                            out_col_r <= out_col_r + COL_ONE;
                        end
                    end
                end
                default: begin
                    out_data_r <= OUT_ZERO;
                    out_row_r  <= ROW_ZERO;
                    out_col_r  <= COL_ZERO;
                    out_done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_systolic_mm.sv
// tb_rsa_systolic_mm: scoreboard bench for rsa_systolic_mm at default sizes.
// Expected C values are computed from the bench's own A/B matrices, queued at
// start time, and popped against out_data on each result cycle.
module tb_rsa_systolic_mm;

    localparam int X   = 3;
    localparam int N   = 4;
    localparam int Y   = 3;
    localparam int LAT = N + X + Y;

    logic       clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       SA_start = 1'b0;
    logic       Xin_val = 1'b0;
    logic [4:1] Xin_data = 4'h0;
    logic       Yin_val = 1'b0;
    logic [4:1] Yin_data = 4'h0;
    logic [8:1] out_data;

    logic [3:0] am [X][N];
    logic [3:0] bm [N][Y];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_fail = 0;

    rsa_systolic_mm dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .SA_start  (SA_start),
        .Xin_val   (Xin_val),
        .Xin_data  (Xin_data),
        .Yin_val   (Yin_val),
        .Yin_data  (Yin_data),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: C = A x B modulo 256, pushed in row-major order.
    task automatic push_expected();
        logic [7:0] s, pa, pb;
        for (int i = 0; i < X; i++)
            for (int j = 0; j < Y; j++) begin
                s = 8'h00;
                for (int k = 0; k < N; k++) begin
                    pa = {4'h0, am[i][k]};
                    pb = {4'h0, bm[k][j]};
                    s  = s + pa * pb;
                end
                exp_q.push_back(s);
            end
    endtask

    task automatic push_zeros();
        for (int i = 0; i < X * Y; i++) exp_q.push_back(8'h00);
    endtask

    // Stream A row-major and B column-major; extra trailing 0xF words, B delayed by y_off.
    task automatic load(input int extra, input int y_off);
        int w;
        for (int t = 0; t < X * N + extra + y_off; t++) begin
            Xin_val  = (t < X * N + extra);
            Xin_data = (t < X * N) ? am[t / N][t % N] : (Xin_val ? 4'hF : 4'h0);
            w        = t - y_off;
            Yin_val  = (w >= 0) && (w < Y * N + extra);
            Yin_data = (w >= 0 && w < Y * N) ? bm[w % N][w / N] : (Yin_val ? 4'hF : 4'h0);
            tick();
        end
        Xin_val  = 1'b0;
        Yin_val  = 1'b0;
        Xin_data = 4'h0;
        Yin_data = 4'h0;
        tick();
    endtask

    // Pulse start, check quiet latency window, drain the scoreboard, check return to 0.
    task automatic run_check(input string name, input int restart_at, input int tail);
        logic [7:0] e;
        int         idx;
        SA_start = 1'b1;
        tick();
        SA_start = 1'b0;
        for (int t = 1; t < LAT; t++) begin
            SA_start = (t == restart_at);
            tick();
            SA_start = 1'b0;
            n_checks++;
            if (out_data !== 8'h00) begin
                n_fail++;
                $display("FAIL %s latency c=%0d got %h exp 00", name, t, out_data);
            end
        end
        idx = 0;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (out_data !== e) begin
                n_fail++;
                $display("FAIL %s result %0d got %h exp %h", name, idx, out_data, e);
            end
            idx++;
        end
        for (int t = 0; t < tail; t++) begin
            tick();
            n_checks++;
            if (out_data !== 8'h00) begin
                n_fail++;
                $display("FAIL %s tail %0d got %h exp 00", name, t, out_data);
            end
        end
    endtask

    task automatic fill(input logic [3:0] av, input logic [3:0] bv);
        for (int i = 0; i < X; i++) for (int k = 0; k < N; k++) am[i][k] = av;
        for (int k = 0; k < N; k++) for (int j = 0; j < Y; j++) bm[k][j] = bv;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold got %h exp 00", out_data);
        end
        sys_rst_n = 1'b1;
        tick();
        n_checks++;
        if (out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release got %h exp 00", out_data);
        end
    endtask

    task automatic test_ones();
        fill(4'h1, 4'h1);
        load(0, 0);
        push_expected();
        run_check("ones", 0, 2);
    endtask

    task automatic test_rows();
        fill(4'h0, 4'h1);
        for (int i = 0; i < X; i++) for (int k = 0; k < N; k++) am[i][k] = 4'(i + 1);
        load(0, 0);
        push_expected();
        run_check("rows", 0, 1);
    endtask

    task automatic test_overrun();
        load(3, 0);
        push_expected();
        run_check("overrun", 0, 1);
    endtask

    task automatic test_wrap();
        fill(4'hF, 4'hF);
        load(0, 0);
        push_expected();
        run_check("wrap", 0, 1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < X; i++) for (int k = 0; k < N; k++) am[i][k] = 4'($urandom_range(0, 15));
            for (int k = 0; k < N; k++) for (int j = 0; j < Y; j++) bm[k][j] = 4'($urandom_range(0, 15));
            load(r, 2 * r);
            push_expected();
            run_check("random", 0, 1);
        end
    endtask

    task automatic test_back_to_back();
        fill(4'h2, 4'h3);
        am[1][2] = 4'h7;
        bm[3][0] = 4'h5;
        load(0, 1);
        push_expected();
        run_check("restart_ignored", 4, 2);
        push_expected();
        run_check("rerun", 0, 1);
    endtask

    task automatic test_abort();
        fill(4'h1, 4'h1);
        load(0, 0);
        SA_start = 1'b1;
        tick();
        SA_start = 1'b0;
        for (int t = 0; t < LAT + 1; t++) tick();
        n_checks++;
        if (out_data !== 8'h04) begin
            n_fail++;
            $display("FAIL abort_pre got %h exp 04", out_data);
        end
        sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_output got %h exp 00", out_data);
        end
        tick();
        sys_rst_n = 1'b1;
        tick();
        load(0, 0);
        SA_start = 1'b1;
        tick();
        SA_start = 1'b0;
        for (int t = 0; t < 4; t++) tick();
        sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_compute got %h exp 00", out_data);
        end
        tick();
        sys_rst_n = 1'b1;
        tick();
        push_zeros();
        run_check("after_abort", 0, 1);
    endtask

    initial begin
        test_reset();
        test_ones();
        test_rows();
        test_overrun();
        test_wrap();
        test_random();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_systolic_mm.md
Name: rsa_systolic_mm

Overview:
- Reconfigurable systolic-array matrix multiplier: computes C = A × B.
  - A is X×N, streamed in on the Xin port.
  - B is N×Y, streamed in on the Yin port.
- Operands are buffered locally. An X×Y output-stationary PE grid performs N multiply-accumulates per PE after a one-cycle SA_start pulse.
- The X·Y results are serialised on out_data.
- Sits as the compute core of the EKF matrix datapath, fed by upstream operand streams.

Parameters:
- X, 3: rows of A, and rows of the PE grid.
- N, 4: shared (inner) dimension, i.e. accumulation depth.
- Y, 3: columns of B, and columns of the PE grid.
- IN_LEN, 4: operand width in bits, unsigned.
- OUT_LEN, 8: result width in bits, unsigned.
- ADDR_WIDTH, 2: operand buffer address width; must satisfy 2^ADDR_WIDTH ≥ N.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- sys_rst_n, input, 1: reset, asynchronous and active-low.
- SA_start, input, 1: one-cycle pulse that starts a multiply.
- Xin_val, input, 1: A-stream valid.
- Xin_data, input, IN_LEN: A element, bit range [IN_LEN:1].
- Yin_val, input, 1: B-stream valid.
- Yin_data, input, IN_LEN: B element, bit range [IN_LEN:1].
- out_data, output, OUT_LEN: serialised C element, bit range [OUT_LEN:1]; 0 when no result is being presented.

Behaviour:
- Reset (asynchronous, sys_rst_n=0):
  - state=IDLE, out_data=0.
  - Write counters, PE accumulators and output counter all cleared.
  - Buffer contents cleared to 0.
  - Reset mid-operation aborts immediately; no partial results are emitted.
- Loading (state IDLE only):
  - A word is captured on each rising edge with Xin_val=1.
  - A order is row-major: word w → A[w/N][w%N]. Stored in row buffer w/N at address w%N.
  - B order is column-major: word w → B[w%N][w/N]. Stored in column buffer w/N at address w%N.
  - Each stream has its own write counter, which saturates at X·N (resp. Y·N).
  - Words beyond the saturation count are ignored while val stays high; earlier entries are never overwritten.
  - A counter resets to 0 on any cycle its val is 0, so the next val burst reloads from element 0.
  - Xin and Yin load independently and may overlap.
  - val inputs are ignored outside IDLE.
- FSM: IDLE → COMPUTE → OUTPUT → IDLE.
  - SA_start is sampled only in IDLE; a start asserted in any other state is ignored.
  - No check for complete loading is performed; missing entries compute as their stored or zero values.
  - A start coinciding with a load edge uses the buffers as they stand before that edge.
- COMPUTE:
  - Timing reference: cycle c=0 is the edge that samples SA_start; this enters COMPUTE with all accumulators cleared.
  - Skewed feed: row i of A enters the left edge i cycles late; column j of B enters the top edge j cycles late.
  - A values shift right and B values shift down one PE per cycle.
  - PE(i,j) performs acc += A[i][k]·B[k][j] on the edge at c = 1+i+j+k, for k = 0..N−1.
  - Invalid or bubble slots carry 0.
  - The last MAC completes at c = N+X+Y−2. State becomes OUTPUT at c = N+X+Y−1.
- Arithmetic:
  - Unsigned IN_LEN×IN_LEN product, zero-extended.
  - Accumulation is modulo 2^OUT_LEN, wrapping silently with no saturation or overflow flag.
- OUTPUT:
  - Results are presented in row-major order: C[0][0], C[0][1], …, C[X−1][Y−1].
  - out_data is registered. The first result appears after edge c = N+X+Y; defaults give 10 cycles after the start edge.
  - One result per cycle for X·Y cycles.
  - On the next edge, out_data returns to 0 and state returns to IDLE.
- Buffers retain their contents after a run, so a second SA_start without reloading recomputes the identical C.

Test Plan:
- Reset, then load A all ones and B all ones (12 words each), then pulse SA_start → out_data = 9 consecutive words of 0x04, starting 10 cycles after the start edge, then 0.
- A row i all equal to i+1, B all ones → sequence 04,04,04,08,08,08,0C,0C,0C.
- Keep Xin_val/Yin_val high for 15 cycles with 3 trailing garbage words (0xF) → result identical to the clean 12-word load; extra words discarded.
- A and B all 0xF → each result 4·225 = 900 mod 256 = 0x84 (wrap check).
- Second SA_start during COMPUTE is ignored (exactly 9 words output). A re-pulse after returning to IDLE reproduces the same 9 words.
- sys_rst_n low mid-COMPUTE → out_data is 0 immediately. After release, a new start without reload yields all zeros (buffers cleared).
